// File: rtl/mdu_unit_pkg.sv
// Shared encodings for the MDU handshake: op codes, HI/LO select and FSM states.
// Both the controller and the MDU import this so the two ends always agree.
package mdu_unit_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;

    localparam logic MDU_HI = 1'b1;
    localparam logic MDU_LO = 1'b0;

    typedef enum logic {
        IDLE,
        RUN
    } mdu_state_e;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit: computes on the issue edge, holds the result in a pending
// buffer and commits it to HI/LO after a fixed latency so the controller can stall.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic        we,
    input  logic        r_sel,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] rd
);

    localparam int CNT_MAX = maxInt(MULT_CYCLES, DIV_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pendHi_q, pendHi_d, pendLo_q, pendLo_d;
    logic          divZero_q, divZero_d;

    logic          go, wr, isMult;
    logic [63:0]   prodS, prodU;
    logic [31:0]   divisor, calcHi, calcLo;

    // A zero divisor is swapped for 1 so the divider never sees it; the result is discarded anyway.
    always_comb begin
        isMult  = (op == MDU_MULT) || (op == MDU_MULTU);
        divisor = (B == 32'd0) ? 32'd1 : B;
        prodS   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prodU   = {32'd0, A} * {32'd0, B};
        calcHi  = 32'd0;
        calcLo  = 32'd0;
        case (op)
            MDU_MULT:  {calcHi, calcLo} = prodS;
            MDU_MULTU: {calcHi, calcLo} = prodU;
            MDU_DIV: begin
                calcLo = 32'($signed({A[31], A}) / $signed({divisor[31], divisor}));
                calcHi = 32'($signed({A[31], A}) % $signed({divisor[31], divisor}));
            end
            default: begin
                calcLo = A / divisor;
                calcHi = A % divisor;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pendHi_q  <= 32'd0;
            pendLo_q  <= 32'd0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pendHi_q  <= pendHi_d;
            pendLo_q  <= pendLo_d;
            divZero_q <= divZero_d;
        end
    end

    // Issue and mthi/mtlo are only honoured while idle; req blocks both in the issue cycle.
    always_comb begin
        go        = start & ~req & (cnt_q == '0);
        wr        = we & ~req & (cnt_q == '0) & ~start;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pendHi_d  = pendHi_q;
        pendLo_d  = pendLo_q;
        divZero_d = divZero_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d   = RUN;
                    cnt_d     = isMult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    pendHi_d  = calcHi;
                    pendLo_d  = calcLo;
                    divZero_d = ~isMult & (B == 32'd0);
                end else if (wr) begin
                    if (r_sel == MDU_HI) hi_d = A;
                    else                 lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (!divZero_q) begin
                        hi_d = pendHi_q;
                        lo_d = pendLo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (start & ~req) | (cnt_q != '0);
    assign rd   = (r_sel == MDU_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: fixed vectors, protocol corner cases and
// random operations compared against a plain-arithmetic reference model.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset, start, we, r_sel, req;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] rd;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[10];

    mdu_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .we(we), .r_sel(r_sel),
        .req(req), .A(A), .B(B), .busy(busy), .rd(rd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: result of one issued op given the previous HI/LO.
    function automatic void refModel(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] oldHi, input logic [31:0] oldLo,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint          sp, sq, sr;
        longint unsigned up;
        hi = oldHi;
        lo = oldLo;
        case (o)
            MDU_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
            end
            MDU_MULTU: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                hi = up[63:32];
                lo = up[31:0];
            end
            MDU_DIV: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                hi = sr[31:0];
                lo = sq[31:0];
            end
            default: if (b != 0) begin
                lo = a / b;
                hi = a % b;
            end
        endcase
    endfunction

    // Issue one op, check busy each cycle plus stale rd, then the committed HI/LO.
    // glitchKind: 1 req mid-op, 2 stray start, 3 we (dropped at the start cycle, ignored later).
    task automatic applyStimulus(input logic [3:0] opV, input logic [31:0] aV, input logic [31:0] bV,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input int glitchAt, input int glitchKind, input bit noWait);
        int n;
        n = (opV == MDU_MULT || opV == MDU_MULTU) ? MULT_CYCLES : DIV_CYCLES;
        if (!noWait) @(negedge clk);
        for (int c = 0; c <= n; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == 0);
            op    = opV;
            A     = (c == 0) ? aV : $urandom;
            B     = (c == 0) ? bV : $urandom;
            we    = 1'b0;
            req   = 1'b0;
            r_sel = c[0];
            if (c == glitchAt) begin
                case (glitchKind)
                    1: req = 1'b1;
                    2: begin start = 1'b1; op = MDU_MULTU; A = ~aV; B = bV + 32'd1; end
                    3: begin we = 1'b1; if (c > 0) A = 32'hA5A5A5A5; end
                    default: ;
                endcase
            end
            #1 checkOutput($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd1);
            #1 checkOutput(r_sel ? "rd_hi_stale" : "rd_lo_stale", rd, r_sel ? modelHi : modelLo);
        end
        @(negedge clk);
        start = 1'b0; we = 1'b0; req = 1'b0;
        A = $urandom; B = $urandom;
        r_sel = MDU_HI;
        #1 checkOutput("busy_done", {31'd0, busy}, 32'd0);
        checkOutput("rd_hi_result", rd, expHi);
        r_sel = MDU_LO;
        #1 checkOutput("rd_lo_result", rd, expLo);
        modelHi = expHi;
        modelLo = expLo;
    endtask

    task automatic randomOp(input int glitchAt, input int glitchKind, input bit noWait);
        logic [3:0]  o;
        logic [31:0] a, b, eh, el;
        int          k;
        k = $urandom_range(0, 5);
        o = (k < 4) ? 4'(k) : 4'($urandom_range(4, 15));
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        refModel(o, a, b, modelHi, modelLo, eh, el);
        applyStimulus(o, a, b, eh, el, glitchAt, glitchKind, noWait);
    endtask

    task automatic idleRead(input string tag);
        r_sel = MDU_HI;
        #1 checkOutput({tag, "_hi"}, rd, modelHi);
        r_sel = MDU_LO;
        #1 checkOutput({tag, "_lo"}, rd, modelLo);
    endtask

    initial begin
        vecs[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{MDU_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{MDU_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[6] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[8] = '{4'hF,      32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[9] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

        reset = 1'b1; start = 1'b0; we = 1'b0; req = 1'b0; r_sel = MDU_LO;
        op = MDU_MULT; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        idleRead("reset_rd");

        for (int i = 0; i < 10; i++)
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, -1, 0, 1'b0);

        // mthi, then mtlo, then a write blocked by req
        @(negedge clk);
        we = 1'b1; r_sel = MDU_HI; A = 32'h12345678;
        #1 checkOutput("we_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        we = 1'b0;
        modelHi = 32'h12345678;
        idleRead("mthi");
        @(negedge clk);
        we = 1'b1; r_sel = MDU_LO; A = 32'h0BADF00D;
        @(negedge clk);
        we = 1'b0;
        modelLo = 32'h0BADF00D;
        idleRead("mtlo");
        @(negedge clk);
        we = 1'b1; req = 1'b1; r_sel = MDU_HI; A = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0; req = 1'b0;
        idleRead("we_req");

        // start suppressed by req
        @(negedge clk);
        start = 1'b1; req = 1'b1; op = MDU_MULT; A = 32'd5; B = 32'd7;
        #1 checkOutput("start_req_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0; req = 1'b0;
        #1 checkOutput("start_req_busy_next", {31'd0, busy}, 32'd0);
        idleRead("start_req");

        begin
            logic [31:0] eh, el;
            refModel(MDU_MULT, 32'hFFFF0001, 32'h00012345, modelHi, modelLo, eh, el);
            applyStimulus(MDU_MULT, 32'hFFFF0001, 32'h00012345, eh, el, 2, 1, 1'b0);
            refModel(MDU_DIV, 32'hF0000000, 32'd3, modelHi, modelLo, eh, el);
            applyStimulus(MDU_DIV, 32'hF0000000, 32'd3, eh, el, 3, 2, 1'b0);
            refModel(MDU_MULTU, 32'h00000011, 32'h00000022, modelHi, modelLo, eh, el);
            applyStimulus(MDU_MULTU, 32'h00000011, 32'h00000022, eh, el, 0, 3, 1'b0);
            refModel(MDU_DIVU, 32'h00001000, 32'd9, modelHi, modelLo, eh, el);
            applyStimulus(MDU_DIVU, 32'h00001000, 32'd9, eh, el, 4, 3, 1'b0);
            // back-to-back: second issue in the first non-busy cycle
            refModel(MDU_MULT, 32'd1234, 32'hFFFFFF00, modelHi, modelLo, eh, el);
            applyStimulus(MDU_MULT, 32'd1234, 32'hFFFFFF00, eh, el, -1, 0, 1'b0);
            refModel(MDU_DIV, 32'h7FFFFFFF, 32'hFFFFFFF0, modelHi, modelLo, eh, el);
            applyStimulus(MDU_DIV, 32'h7FFFFFFF, 32'hFFFFFFF0, eh, el, -1, 0, 1'b1);
        end

        // reset three cycles into a div discards it
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; A = 32'd100; B = 32'd3;
        repeat (2) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelHi = 32'd0;
        modelLo = 32'd0;
        #1 checkOutput("reset_mid_busy", {31'd0, busy}, 32'd0);
        idleRead("reset_mid");
        repeat (12) @(negedge clk);
        #1 checkOutput("reset_late_busy", {31'd0, busy}, 32'd0);
        idleRead("reset_late");

        for (int i = 0; i < 40; i++)
            randomOp(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1,
                     int'($urandom_range(1, 3)), (i % 5) == 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage; the responder end of the controller's MDU handshake (start, op, we, r_sel, busy).
- Latches operands on start, computes a 64-bit product or a quotient/remainder, and commits it to HI/LO after a fixed latency.
- Asserts busy so the controller stalls mult/div/mfhi/mflo/mthi/mtlo.
- Serves mthi/mtlo writes and the mfhi/mflo read path.

Parameters:
- MULT_CYCLES, 5, busy cycles after the start edge for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles after the start edge for div/divu (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage mult/multu/div/divu issue strobe.
- op  input  4  mdu_mult / mdu_multu / mdu_div / mdu_divu (shared macros).
- we  input  1  mthi/mtlo write strobe.
- r_sel  input  1  mdu_hi selects HI, mdu_lo selects LO, for both read and we.
- req  input  1  exception/interrupt taken this cycle; suppresses start and we.
- A  input  32  rs operand, also the mthi/mtlo write data.
- B  input  32  rt operand.
- busy  output  1  high during the start cycle and during every in-flight cycle.
- rd  output  32  HI if r_sel==mdu_hi, else LO; combinational from HI/LO registers.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset clears HI, LO, cnt, pend_hi and pend_lo to 0, so busy=0 and rd=0. This also applies mid-operation: the in-flight result is discarded.
- Effective strobes:
  - go = start & ~req & (cnt==0)
  - wr = we & ~req & (cnt==0) & ~start
- busy = (start & ~req) | (cnt!=0). The start cycle counts as busy, so an mfhi in D is stalled in the same cycle a mult sits in E.
- On go, one edge:
  - Compute into pend_hi/pend_lo from A/B as sampled that cycle.
  - mult: signed 64-bit product; pend_hi = [63:32], pend_lo = [31:0].
  - multu: the same, unsigned.
  - div: signed; pend_lo = quotient truncated toward zero; pend_hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - cnt loads MULT_CYCLES or DIV_CYCLES.
- Division by zero (B==0): no commit. HI/LO keep their values; busy timing is unchanged.
- div overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0.
- While cnt!=0: cnt decrements by 1 per cycle. On the edge where cnt goes 1->0, HI<=pend_hi and LO<=pend_lo (unless flagged divide-by-zero).
- Latency: with start in cycle T, busy is high for T..T+N and the new HI/LO are visible on rd in T+N+1, where N is the matching parameter.
- rd during busy returns the old HI/LO. The controller never reads then, because it stalls.
- wr: HI<=A if r_sel==mdu_hi, else LO<=A, visible on the next cycle.
- start or we while cnt!=0 is a protocol violation and is ignored. Neither the in-flight op nor HI/LO is altered.
- start and we in the same cycle: start wins and we is dropped.
- req only gates the issue cycle. An op already in flight (cnt!=0) is not aborted by req and always completes.
- Unknown op value with start: treated as divu.
- Implemented as an FSM with two states:
  - IDLE (cnt==0): go -> RUN.
  - RUN: stays in RUN while cnt>1; goes to IDLE with commit when cnt==1.

Decomposition:
- Shared macros file holds `mdu_mult`=0, `mdu_multu`=1, `mdu_div`=2, `mdu_divu`=3, `mdu_hi`=1, `mdu_lo`=0, so both ends of the handshake use one set of encodings.
- No sub-module is needed. Compute logic is inline; cnt width is derived from max(MULT_CYCLES, DIV_CYCLES).

Test Plan:
- mult: A=0xFFFFFFFE (-2), B=3, start at T. Busy high T..T+5; in T+6, rd(hi)=0xFFFFFFFF and rd(lo)=0xFFFFFFFA. multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div: A=-7, B=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles plus the start cycle. divu A=7, B=0 leaves HI/LO unchanged and still holds busy for 11 cycles.
- mthi A=0x12345678 then mflo/mfhi: rd(hi)=0x12345678 next cycle, LO unchanged. The same we with req=1: no write.
- start with req=1: busy=0 that cycle, cnt stays 0, HI/LO unchanged. req asserted mid-mult: result still commits on schedule.
- reset asserted at T+3 of a div: the next cycle shows busy=0, HI=LO=0, and no late commit. A start issued while cnt!=0 is ignored; the first result commits intact.
- Back-to-back: mult completes, then a start in the first non-busy cycle. The second op's operands are latched correctly and HI/LO reflect the second result only after its latency.
